// File: rtl/adder_share_sequencer_if.sv
// Bundles the requester bus and the shared 4-bit adder connection.
// The sequencer takes the slave modport; the requesters/adder side take the master modport.
interface adder_share_sequencer_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 16
);
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*WIDTH-1:0] op_a;
   logic [NUM_REQ*WIDTH-1:0] op_b;
   logic [NUM_REQ-1:0]       c_in;
   logic [NUM_REQ-1:0]       grant;
   logic                     busy;
   logic                     done;
   logic [WIDTH-1:0]         result;
   logic                     c_out;
   logic [3:0]               add_a;
   logic [3:0]               add_b;
   logic                     add_cin;
   logic [3:0]               add_sum;
   logic                     add_cout;

   modport master (
      output req, op_a, op_b, c_in, add_sum, add_cout,
      input  grant, busy, done, result, c_out, add_a, add_b, add_cin
   );

   modport slave (
      input  req, op_a, op_b, c_in, add_sum, add_cout,
      output grant, busy, done, result, c_out, add_a, add_b, add_cin
   );
endinterface

// File: rtl/adder_share_sequencer.sv
// Round-robin time-sharing of one external 4-bit adder; WIDTH-bit adds are
// done one nibble per cycle, LSB first, with the carry registered between passes.
//
// state | meaning
// IDLE  | no owner; arbitrate among req from the round-robin pointer
// RUN   | feeding nibble idx of the latched operands to the adder
// DONE  | one-cycle done pulse; owner released and pointer advanced
module adder_share_sequencer #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 16
) (
   input logic                    clk,
   input logic                    rst_n,
   adder_share_sequencer_if.slave bus
);
   localparam int NIB  = WIDTH / 4;
   localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [NUM_REQ-1:0][WIDTH-1:0] op_a_v, op_b_v;
   logic [NIB-1:0][3:0]           a_q, b_q, result_q;
   logic                          cin_q, carry_q, c_out_q, done_q;
   logic [IDXW-1:0]               idx_q;
   logic [PW-1:0]                 ptr_q, winner_q, win;
   logic [NUM_REQ-1:0]            grant_q;
   logic [PW:0]                   cand;
   logic                          found, last_nib;

   assign op_a_v = bus.op_a;
   assign op_b_v = bus.op_b;

   // First set req at or above the pointer, wrapping at NUM_REQ.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, ptr_q} + (PW+1)'(i);
         if (cand >= (PW+1)'(NUM_REQ)) cand = cand - (PW+1)'(NUM_REQ);
         if (!found && bus.req[cand[PW-1:0]]) begin
            found = 1'b1;
            win   = cand[PW-1:0];
         end
      end
   end

   assign last_nib = (idx_q == IDXW'(NIB - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (found) state_d = RUN;
         RUN:     if (last_nib) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         grant_q  <= '0;
         a_q      <= '0;
         b_q      <= '0;
         cin_q    <= 1'b0;
         carry_q  <= 1'b0;
         idx_q    <= '0;
         ptr_q    <= '0;
         winner_q <= '0;
         result_q <= '0;
         c_out_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (found) begin
                  grant_q  <= NUM_REQ'(1) << win;
                  a_q      <= op_a_v[win];
                  b_q      <= op_b_v[win];
                  cin_q    <= bus.c_in[win];
                  winner_q <= win;
                  idx_q    <= '0;
               end
            end
            RUN: begin
               result_q[idx_q] <= bus.add_sum;
               carry_q         <= bus.add_cout;
               idx_q           <= idx_q + IDXW'(1);
               if (last_nib) begin
                  c_out_q <= bus.add_cout;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               grant_q <= '0;
               ptr_q   <= (winner_q == PW'(NUM_REQ - 1)) ? '0 : winner_q + PW'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.grant   = grant_q;
   assign bus.busy    = (state_q == RUN) || (state_q == DONE);
   assign bus.done    = done_q;
   assign bus.result  = result_q;
   assign bus.c_out   = c_out_q;
   assign bus.add_a   = (state_q == RUN) ? a_q[idx_q] : 4'h0;
   assign bus.add_b   = (state_q == RUN) ? b_q[idx_q] : 4'h0;
   assign bus.add_cin = (state_q == RUN) && ((idx_q == '0) ? cin_q : carry_q);
endmodule

// File: tb/tb_adder_share_sequencer.sv
// Directed bench for adder_share_sequencer (4 requesters, 16-bit) with a
// behavioural 4-bit adder on the shared-adder port.
module tb_adder_share_sequencer;
   logic clk;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   adder_share_sequencer_if #(.NUM_REQ(4), .WIDTH(16)) bus ();

   adder_share_sequencer #(.NUM_REQ(4), .WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign {bus.add_cout, bus.add_sum} = bus.add_a + bus.add_b + bus.add_cin;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int r, input logic [15:0] a, input logic [15:0] b, input logic ci);
      bus.op_a[r*16 +: 16] = a;
      bus.op_b[r*16 +: 16] = b;
      bus.c_in[r]          = ci;
   endtask

   // req must already be set; returns one cycle after DONE, back in IDLE.
   task automatic expect_op(input string tag, input int gidx, input logic [15:0] er,
                            input logic ec, input logic [3:0] req_after, input bit scramble);
      tick();
      chk({tag, " grant"}, 32'(bus.grant), 32'(4'b0001 << gidx));
      chk({tag, " busy_run"}, 32'(bus.busy), 32'd1);
      chk({tag, " done_early0"}, 32'(bus.done), 32'd0);
      bus.req = req_after;
      if (scramble) begin
         bus.op_a[gidx*16 +: 16] = ~bus.op_a[gidx*16 +: 16];
         bus.op_b[gidx*16 +: 16] = 16'h0F0F;
         bus.c_in[gidx]          = ~bus.c_in[gidx];
      end
      for (int k = 1; k < 4; k++) begin
         tick();
         chk({tag, " done_early"}, 32'(bus.done), 32'd0);
      end
      tick();
      chk({tag, " done"}, 32'(bus.done), 32'd1);
      chk({tag, " result"}, 32'(bus.result), 32'(er));
      chk({tag, " c_out"}, 32'(bus.c_out), 32'(ec));
      chk({tag, " grant_done"}, 32'(bus.grant), 32'(4'b0001 << gidx));
      chk({tag, " busy_done"}, 32'(bus.busy), 32'd1);
      tick();
      chk({tag, " done_clr"}, 32'(bus.done), 32'd0);
      chk({tag, " grant_clr"}, 32'(bus.grant), 32'd0);
      chk({tag, " busy_clr"}, 32'(bus.busy), 32'd0);
   endtask

   logic [3:0] ta [4];
   logic [3:0] tb [4];
   logic       tc [4];

   initial begin
      rst_n    = 1'b0;
      bus.req  = '0;
      bus.op_a = '0;
      bus.op_b = '0;
      bus.c_in = '0;
      tick();
      tick();
      chk("rst grant", 32'(bus.grant), 32'd0);
      chk("rst busy", 32'(bus.busy), 32'd0);
      chk("rst done", 32'(bus.done), 32'd0);
      chk("rst result", 32'(bus.result), 32'd0);
      chk("rst c_out", 32'(bus.c_out), 32'd0);
      chk("rst add_a", 32'(bus.add_a), 32'd0);
      chk("rst add_b", 32'(bus.add_b), 32'd0);
      chk("rst add_cin", 32'(bus.add_cin), 32'd0);
      rst_n = 1'b1;
      tick();

      // carry ripples through every nibble
      set_op(0, 16'hFFFF, 16'h0001, 1'b0);
      bus.req = 4'b0001;
      expect_op("ripple", 0, 16'h0000, 1'b1, 4'b0000, 1'b0);

      // carry-in path, traced nibble by nibble
      set_op(1, 16'h0F0F, 16'h00F1, 1'b1);
      ta = '{4'hF, 4'h0, 4'hF, 4'h0};
      tb = '{4'h1, 4'hF, 4'h0, 4'h0};
      tc = '{1'b1, 1'b1, 1'b1, 1'b1};
      bus.req = 4'b0010;
      tick();
      chk("cin grant", 32'(bus.grant), 32'b0010);
      bus.req = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("cin add_a%0d", k), 32'(bus.add_a), 32'(ta[k]));
         chk($sformatf("cin add_b%0d", k), 32'(bus.add_b), 32'(tb[k]));
         chk($sformatf("cin add_cin%0d", k), 32'(bus.add_cin), 32'(tc[k]));
         tick();
      end
      chk("cin done", 32'(bus.done), 32'd1);
      chk("cin result", 32'(bus.result), 32'h1001);
      chk("cin c_out", 32'(bus.c_out), 32'd0);
      tick();
      chk("cin add_a idle", 32'(bus.add_a), 32'd0);
      chk("cin done clr", 32'(bus.done), 32'd0);

      // pointer now 2: 3 wins before 1
      set_op(0, 16'h1234, 16'h4321, 1'b0);
      set_op(1, 16'h8000, 16'h8000, 1'b1);
      set_op(2, 16'h00FF, 16'h0001, 1'b0);
      set_op(3, 16'hFFFF, 16'hFFFF, 1'b1);
      bus.req = 4'b1010;
      expect_op("rr1010 a", 3, 16'hFFFF, 1'b1, 4'b1010, 1'b0);
      expect_op("rr1010 b", 1, 16'h0001, 1'b1, 4'b0000, 1'b0);

      bus.req = 4'b1000;
      expect_op("rr to0", 3, 16'hFFFF, 1'b1, 4'b0000, 1'b0);

      bus.req = 4'b1111;
      expect_op("rr1111 r0", 0, 16'h5555, 1'b0, 4'b1111, 1'b0);
      expect_op("rr1111 r1", 1, 16'h0001, 1'b1, 4'b1111, 1'b0);
      expect_op("rr1111 r2", 2, 16'h0100, 1'b0, 4'b1111, 1'b0);
      expect_op("rr1111 r3", 3, 16'hFFFF, 1'b1, 4'b1111, 1'b0);
      expect_op("rr1111 r0b", 0, 16'h5555, 1'b0, 4'b0000, 1'b0);

      // operands and req changed right after capture
      set_op(0, 16'h1234, 16'h4321, 1'b0);
      bus.req = 4'b0001;
      expect_op("stable", 0, 16'h5555, 1'b0, 4'b0000, 1'b1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stable no_regrant", 32'(bus.grant), 32'd0);
      end

      // reset while RUN idx=2
      set_op(2, 16'hAAAA, 16'h5555, 1'b1);
      bus.req = 4'b0100;
      tick();
      chk("mrst grant", 32'(bus.grant), 32'b0100);
      bus.req = 4'b0000;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      chk("mrst grant0", 32'(bus.grant), 32'd0);
      chk("mrst busy", 32'(bus.busy), 32'd0);
      chk("mrst result", 32'(bus.result), 32'd0);
      chk("mrst c_out", 32'(bus.c_out), 32'd0);
      chk("mrst done", 32'(bus.done), 32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("mrst no_done", 32'(bus.done), 32'd0);
         chk("mrst idle", 32'(bus.busy), 32'd0);
      end
      set_op(0, 16'hFFFF, 16'h0002, 1'b0);
      bus.req = 4'b1001;
      expect_op("post_rst ptr0", 0, 16'h0001, 1'b1, 4'b0000, 1'b0);

      // idle hold
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("hold grant", 32'(bus.grant), 32'd0);
         chk("hold done", 32'(bus.done), 32'd0);
         chk("hold result", 32'(bus.result), 32'h0001);
         chk("hold c_out", 32'(bus.c_out), 32'd1);
         chk("hold add_a", 32'(bus.add_a), 32'd0);
         chk("hold add_b", 32'(bus.add_b), 32'd0);
         chk("hold add_cin", 32'(bus.add_cin), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
